// File: rtl/riscv_ahb_pkg.sv
// Shared AHB-Lite types and constants for the fetch/ldst bus arbiter.
package riscv_ahb_pkg;

    localparam int unsigned AHB_AW = 32;
    localparam int unsigned AHB_DW = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Which master owns a bus phase
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LDST = 2'd1,
        OWN_CODE = 2'd2
    } owner_e;

    // Address-phase payload of one AHB transfer
    typedef struct packed {
        logic [AHB_AW-1:0] haddr;
        logic [1:0]        htrans;
        logic              hwrite;
        logic [2:0]        hsize;
        logic [2:0]        hburst;
        logic [3:0]        hprot;
        logic              hmastlock;
    } ahb_addr_t;

endpackage

// File: rtl/riscv_ahb_arbiter_if.sv
// One AHB-Lite bus: master drives address/control/write data, slave drives responses.
interface riscv_ahb_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic          hmastlock;
    logic [DW-1:0] hwdata;
    logic [DW-1:0] hrdata;
    logic          hready;
    logic          hresp;

    modport master (
        output haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/riscv_ahb_hold_buf.sv
// One-entry holding register for an address phase that lost arbitration.
module riscv_ahb_hold_buf
    import riscv_ahb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      capture,
    input  logic      clear,
    input  ahb_addr_t d,
    output logic      valid,
    output ahb_addr_t q
);

    // Capture wins over clear; the two never coincide in practice
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (capture) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/riscv_ahb_arbiter.sv
// 2:1 round-robin AHB-Lite arbiter between ldst and fetch masters onto one memory port.
module riscv_ahb_arbiter
    import riscv_ahb_pkg::*;
#(
    parameter int unsigned AW = AHB_AW,
    parameter int unsigned DW = AHB_DW
) (
    input logic                 CLK,
    input logic                 RST,
    riscv_ahb_arbiter_if.slave  ldst,
    riscv_ahb_arbiter_if.slave  if_code,
    riscv_ahb_arbiter_if.master mem
);

    owner_e    dph_q, last_q, grant;
    logic      lock_q;
    ahb_addr_t live_l, live_c, pend_l, pend_c, cand_l, cand_c, gnt_a;
    logic      pend_l_vld, pend_c_vld;
    logic      l_hready_c, c_hready_c, issue_l, issue_c;
    logic      cand_l_vld, cand_c_vld;
    logic      capture_l, capture_c, clear_l, clear_c;
    logic      unused_code_hwdata;

    assign live_l = '{haddr: AHB_AW'(ldst.haddr), htrans: ldst.htrans, hwrite: ldst.hwrite,
                      hsize: ldst.hsize, hburst: ldst.hburst, hprot: ldst.hprot,
                      hmastlock: ldst.hmastlock};
    assign live_c = '{haddr: AHB_AW'(if_code.haddr), htrans: if_code.htrans, hwrite: if_code.hwrite,
                      hsize: if_code.hsize, hburst: if_code.hburst, hprot: if_code.hprot,
                      hmastlock: if_code.hmastlock};

    // Fetch write data is never forwarded
    assign unused_code_hwdata = ^if_code.hwdata;

    riscv_ahb_hold_buf u_hold_ldst (
        .clk     (CLK),
        .rst     (RST),
        .capture (capture_l),
        .clear   (clear_l),
        .d       (live_l),
        .valid   (pend_l_vld),
        .q       (pend_l)
    );

    riscv_ahb_hold_buf u_hold_code (
        .clk     (CLK),
        .rst     (RST),
        .capture (capture_c),
        .clear   (clear_c),
        .d       (live_c),
        .valid   (pend_c_vld),
        .q       (pend_c)
    );

    // Master-side ready, candidate selection, grant and hold-buffer control
    always_comb begin
        l_hready_c = 1'b1;
        c_hready_c = 1'b1;
        grant      = OWN_NONE;
        if (!RST) begin
            l_hready_c = (dph_q == OWN_LDST) ? mem.hready : ~pend_l_vld;
            c_hready_c = (dph_q == OWN_CODE) ? mem.hready : ~pend_c_vld;
        end
        issue_l    = ldst.htrans[1] & l_hready_c & ~RST;
        issue_c    = if_code.htrans[1] & c_hready_c & ~RST;
        cand_l_vld = pend_l_vld | issue_l;
        cand_c_vld = pend_c_vld | issue_c;
        cand_l     = pend_l_vld ? pend_l : live_l;
        cand_c     = pend_c_vld ? pend_c : live_c;
        if (mem.hready && !RST) begin
            if (cand_l_vld && cand_c_vld) begin
                if (lock_q) begin
                    grant = last_q;
                end else begin
                    grant = (last_q == OWN_LDST) ? OWN_CODE : OWN_LDST;
                end
            end else if (cand_l_vld) begin
                grant = OWN_LDST;
            end else if (cand_c_vld) begin
                grant = OWN_CODE;
            end
        end
        capture_l = issue_l & (grant != OWN_LDST);
        capture_c = issue_c & (grant != OWN_CODE);
        clear_l   = pend_l_vld & (grant == OWN_LDST);
        clear_c   = pend_c_vld & (grant == OWN_CODE);
    end

    // Memory address-phase mux; a change of owner restarts with NONSEQ
    always_comb begin
        gnt_a = live_l;
        if (grant == OWN_LDST) begin
            gnt_a = cand_l;
        end else if (grant == OWN_CODE) begin
            gnt_a = cand_c;
        end
        mem.haddr     = AW'(gnt_a.haddr);
        mem.hwrite    = gnt_a.hwrite;
        mem.hsize     = gnt_a.hsize;
        mem.hburst    = gnt_a.hburst;
        mem.hprot     = gnt_a.hprot;
        mem.hmastlock = gnt_a.hmastlock;
        if (grant == OWN_NONE) begin
            mem.htrans = HTRANS_IDLE;
        end else if (grant != last_q) begin
            mem.htrans = HTRANS_NONSEQ;
        end else begin
            mem.htrans = gnt_a.htrans;
        end
    end

    // Write data follows the data-phase owner; responses go to that owner only
    assign mem.hwdata      = (dph_q == OWN_LDST && !RST) ? ldst.hwdata : {DW{1'b0}};
    assign ldst.hready     = l_hready_c;
    assign if_code.hready  = c_hready_c;
    assign ldst.hresp      = (dph_q == OWN_LDST) & mem.hresp & ~RST;
    assign if_code.hresp   = (dph_q == OWN_CODE) & mem.hresp & ~RST;
    assign ldst.hrdata     = mem.hrdata;
    assign if_code.hrdata  = mem.hrdata;

    // Data-phase owner, round-robin pointer and lock state
    always_ff @(posedge CLK) begin
        if (RST) begin
            dph_q  <= OWN_NONE;
            last_q <= OWN_CODE;
            lock_q <= 1'b0;
        end else if (mem.hready) begin
            dph_q <= grant;
            if (grant != OWN_NONE) begin
                last_q <= grant;
                lock_q <= gnt_a.hmastlock;
            end
        end
    end

endmodule
